// File: rtl/gf256_xinv_iter_if.sv
// Handshake bundle for gf256_xinv_iter: byte/count request side and result side.
// The master modport drives requests and accepts results; the slave modport is the block itself.
interface gf256_xinv_iter_if #(
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [CNT_W-1:0] in_shift;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;

  modport master (
    output in_valid, in_data, in_shift, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shift, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gf256_xinv_iter.sv
// Divides a byte by x^k in GF(2^8) (poly 0x11B), one x^-1 step per clock; result k+1 cycles after accept.
// Holds the result in DONE until out_ready; new input is only taken in IDLE, independent of out_ready.
module gf256_xinv_iter #(
  parameter int         CNT_W    = 4,
  parameter logic [7:0] POLY_INV = 8'h8D
) (
  input  logic              clk,
  input  logic              rst_n,
  gf256_xinv_iter_if.slave  bus,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       data_q;
  logic [CNT_W-1:0] cnt_q;

  // Undoes one xtime: a set LSB means 0x11B was folded in, so shift it back out.
  function automatic logic [7:0] xinv(input logic [7:0] d);
    return {1'b0, d[7:1]} ^ (d[0] ? POLY_INV : 8'h00);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = (bus.in_shift == '0) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        state_d = (cnt_q == CNT_W'(1)) ? DONE : RUN;
      end
      DONE: begin
        state_d = bus.out_ready ? IDLE : DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q == RUN) || (state_q == DONE);
  end

  // RUN is only entered with a non-zero count, so the decrement cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
      cnt_q  <= '0;
    end else if ((state_q == IDLE) && bus.in_valid) begin
      data_q <= bus.in_data;
      cnt_q  <= bus.in_shift;
    end else if (state_q == RUN) begin
      data_q <= xinv(data_q);
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.out_data = data_q;

endmodule

// File: tb/tb_gf256_xinv_iter.sv
// Bench for gf256_xinv_iter: directed vectors, backpressure, mid-run reset, back-to-back and random ops.
module tb_gf256_xinv_iter;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  logic busy;
  int   cyc;
  int   tests_run;
  int   tests_failed;

  gf256_xinv_iter_if #(.CNT_W(CNT_W)) bus ();

  gf256_xinv_iter #(.CNT_W(CNT_W), .POLY_INV(8'h8D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic: plain GF(2^8) multiplication, with x^-k taken as x^(255-k).
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow(input logic [7:0] a, input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = gf_mul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] y, input int k);
    return gf_mul(y, gf_pow(8'h02, 255 - k));
  endfunction

  function automatic logic [7:0] fwd(input logic [7:0] r, input int k);
    logic [7:0] v;
    v = r;
    for (int i = 0; i < k; i++) v = xt(v);
    return v;
  endfunction

  // Results of the last do_op call.
  logic [7:0] op_res;
  int         op_lat;
  bit         op_ok;
  bit         op_stable;
  bit         op_post;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] d, input int k, input int stall);
    int n;
    int c0;
    op_ok         = 1'b1;
    op_stable     = 1'b1;
    op_post       = 1'b1;
    op_lat        = -1;
    op_res        = 8'h00;
    bus.in_data   = d;
    bus.in_shift  = CNT_W'(k);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.in_ready) begin
      op_ok = 1'b0;
      bus.in_valid = 1'b0;
      return;
    end
    c0 = cyc;
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      step();
      n++;
    end
    if (!bus.out_valid) begin
      op_ok = 1'b0;
      return;
    end
    op_lat = cyc - c0;
    op_res = bus.out_data;
    for (int i = 0; i < stall; i++) begin
      step();
      if (bus.out_data !== op_res || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) op_stable = 1'b0;
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) op_post = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, busy} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h busy=%b, want 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.out_data, busy);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [7:0] vd  [6];
    int         vk  [6];
    logic [7:0] ve  [6];
    vd = '{8'h57, 8'h1B, 8'h01, 8'h04, 8'h1B, 8'hFF};
    vk = '{0, 1, 1, 2, 3, 15};
    ve = '{8'h57, 8'h80, 8'h8D, 8'h01, 8'h20, model(8'hFF, 15)};
    for (int i = 0; i < 6; i++) begin
      do_op(vd[i], vk[i], 0);
      tests_run++;
      if (!op_ok || op_res !== ve[i]) begin
        tests_failed++;
        $display("FAIL directed_data[%0d]: got %h ok=%b, want %h", i, op_res, op_ok, ve[i]);
      end
      tests_run++;
      if (op_lat != 1 + vk[i]) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, op_lat, 1 + vk[i]);
      end
      tests_run++;
      if (!op_post) begin
        tests_failed++;
        $display("FAIL directed_release[%0d]: out_valid=%b in_ready=%b after accept, want 0 1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int  n;
    bit  bad;
    bad = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = 8'h1B;
    bus.in_shift  = CNT_W'(3);
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = 8'hC3;
      bus.in_shift = CNT_W'(5);
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h20 || bus.in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (bad || bus.out_data !== 8'h20) begin
      tests_failed++;
      $display("FAIL backpressure_hold: out_data=%h out_valid=%b in_ready=%b, want 20 1 0 held",
               bus.out_data, bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
               bus.out_valid, bus.in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    seen = 1'b0;
    bus.in_data  = 8'hA5;
    bus.in_shift = CNT_W'(15);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_busy: busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, busy} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b out_data=%h busy=%b, want 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.out_data, busy);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_no_output: out_valid_seen=%b in_ready=%b, want 0 1", seen, bus.in_ready);
    end
    do_op(8'h01, 1, 0);
    tests_run++;
    if (!op_ok || op_res !== 8'h8D) begin
      tests_failed++;
      $display("FAIL midrun_recover: got %h ok=%b, want 8d", op_res, op_ok);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    bit overlap;
    int n;
    overlap = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h04;
    bus.in_shift  = CNT_W'(2);
    for (int i = 0; i < 40 && acc.size() < 3; i++) begin
      if (bus.in_ready) acc.push_back(cyc);
      if (bus.in_ready && bus.out_valid) overlap = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      step();
      n++;
    end
    bus.out_ready = 1'b0;
    tests_run++;
    if (acc.size() != 3 || overlap) begin
      tests_failed++;
      $display("FAIL b2b_accepts: accepts=%0d overlap=%b, want 3 0", acc.size(), overlap);
    end else begin
      tests_run++;
      if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
        tests_failed++;
        $display("FAIL b2b_spacing: gaps %0d %0d, want 4 4", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int         k;
    int         s;
    int         nfail;
    nfail = 0;
    for (int i = 0; i < 1000; i++) begin
      d = 8'($urandom_range(0, 255));
      k = $urandom_range(0, 15);
      s = $urandom_range(0, 3);
      do_op(d, k, s);
      tests_run++;
      if (!op_ok || op_res !== model(d, k) || fwd(op_res, k) !== d) begin
        tests_failed++;
        nfail++;
        if (nfail < 10)
          $display("FAIL random_data[%0d]: d=%h k=%0d got %h ok=%b, want %h", i, d, k, op_res, op_ok, model(d, k));
      end
      tests_run++;
      if (op_lat != 1 + k || !op_stable || !op_post) begin
        tests_failed++;
        nfail++;
        if (nfail < 10)
          $display("FAIL random_handshake[%0d]: k=%0d lat=%0d stable=%b post=%b, want lat %0d 1 1",
                   i, k, op_lat, op_stable, op_post, 1 + k);
      end
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_shift  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
